// File: rtl/controle_operandos_ula_if.sv
// Bundles the pushbutton/switch inputs, the adder connection and the
// result/flag outputs of the operand controller.
interface controle_operandos_ula_if #(
    parameter int WIDTH = 4
);
    // Board side and adder-result side (inputs to the controller)
    logic             botao;
    logic             limpar;
    logic [WIDTH-1:0] dado;
    logic             cin_in;
    logic [WIDTH-1:0] soma_in;
    logic             cout_in;

    // Adder operands and display side (outputs of the controller)
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin_out;
    logic [WIDTH-1:0] resultado;
    logic             carry;
    logic             zero;
    logic             overflow;
    logic             valido;
    logic [1:0]       estado;

    // Controller view
    modport slave (
        input  botao, limpar, dado, cin_in, soma_in, cout_in,
        output op_a, op_b, cin_out, resultado, carry, zero, overflow,
               valido, estado
    );

    // Environment view: board I/O, adder and display
    modport master (
        output botao, limpar, dado, cin_in, soma_in, cout_in,
        input  op_a, op_b, cin_out, resultado, carry, zero, overflow,
               valido, estado
    );
endinterface

// File: rtl/controle_operandos_ula.sv
// Operand capture and result registration around an external ripple adder.
// A synchronized button press loads operand A, then operand B with carry-in;
// one cycle later the adder result and its status flags are captured.
module controle_operandos_ula #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    controle_operandos_ula_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        ESPERA_A  = 2'b00,
        ESPERA_B  = 2'b01,
        CALCULA   = 2'b10,
        RESULTADO = 2'b11
    } estado_t;

    // Button synchronizer chain plus the previous-value flop for edge detect
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   ev;

    estado_t          state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             valido_q, valido_d;

    // Shift the raw button into the synchronizer; remember last synced value
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.botao};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // One pulse per rising edge of the synchronized button
    assign ev = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Synchronizer registers; limpar deliberately does not touch these so a
    // held button cannot produce a second event after a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Next-state and datapath load decisions; limpar outranks a button event
    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        cin_d    = cin_q;
        res_d    = res_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        valido_d = valido_q;

        if (bus.limpar) begin
            state_d  = ESPERA_A;
            op_a_d   = '0;
            op_b_d   = '0;
            cin_d    = 1'b0;
            res_d    = '0;
            carry_d  = 1'b0;
            zero_d   = 1'b0;
            ovf_d    = 1'b0;
            valido_d = 1'b0;
        end else begin
            case (state_q)
                ESPERA_A: begin
                    if (ev) begin
                        op_a_d  = bus.dado;
                        state_d = ESPERA_B;
                    end
                end
                ESPERA_B: begin
                    if (ev) begin
                        op_b_d  = bus.dado;
                        cin_d   = bus.cin_in;
                        state_d = CALCULA;
                    end
                end
                CALCULA: begin
                    // Operands have been stable for a full cycle; the adder
                    // output is settled and can be captured. Events here are
                    // dropped.
                    res_d    = bus.soma_in;
                    carry_d  = bus.cout_in;
                    zero_d   = (bus.soma_in == '0);
                    ovf_d    = (op_a_q[MSB] == op_b_q[MSB]) &&
                               (bus.soma_in[MSB] != op_a_q[MSB]);
                    valido_d = 1'b1;
                    state_d  = RESULTADO;
                end
                RESULTADO: begin
                    if (ev) begin
                        valido_d = 1'b0;
                        state_d  = ESPERA_A;
                    end
                end
                default: state_d = ESPERA_A;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ESPERA_A;
            op_a_q   <= '0;
            op_b_q   <= '0;
            cin_q    <= 1'b0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            valido_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            cin_q    <= cin_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            valido_q <= valido_d;
        end
    end

    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.cin_out   = cin_q;
    assign bus.resultado = res_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.valido    = valido_q;
    assign bus.estado    = state_q;
endmodule

// File: tb/tb_controle_operandos_ula.sv
// Bench for controle_operandos_ula: directed scenarios plus random operand
// pairs checked against an integer-arithmetic model of the adder result.
module tb_controle_operandos_ula;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    controle_operandos_ula_if #(.WIDTH(4)) bus ();

    controle_operandos_ula #(.WIDTH(4), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Environment: the combinational 4-bit adder fed by the controller
    assign {bus.cout_in, bus.soma_in} = 5'(bus.op_a) + 5'(bus.op_b) + 5'(bus.cin_out);

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Raise the button and return just after the edge that acts on the event
    task automatic press_begin(input logic [3:0] val, input logic c);
        bus.dado   = val;
        bus.cin_in = c;
        bus.botao  = 1'b1;
        repeat (3) tick();
    endtask

    task automatic press_end();
        bus.botao = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.op_a, bus.op_b, bus.cin_out, bus.resultado, bus.carry, bus.zero,
             bus.overflow, bus.valido, bus.estado} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs got op_a=%0d op_b=%0d res=%0d valido=%0b estado=%0b required all zero",
                     bus.op_a, bus.op_b, bus.resultado, bus.valido, bus.estado);
        end
        $display("reset: estado=%0b valido=%0b", bus.estado, bus.valido);
    endtask

    // Full A / B / result / acknowledge cycle with cycle-accurate checks
    task automatic run_op(input int a, input int b, input int c);
        int s, sa, sb, ss;
        logic [3:0] e_sum;
        logic e_carry, e_zero, e_ovf;
        s       = a + b + c;
        e_sum   = s[3:0];
        e_carry = (s >= 16);
        e_zero  = (e_sum == 4'd0);
        sa      = (a >= 8) ? a - 16 : a;
        sb      = (b >= 8) ? b - 16 : b;
        ss      = sa + sb + c;
        e_ovf   = (ss > 7) || (ss < -8);

        press_begin(a[3:0], 1'b0);
        checks++;
        if (bus.estado !== 2'b01 || bus.op_a !== a[3:0]) begin
            errors++;
            $display("FAIL load_a got estado=%0b op_a=%0d required estado=01 op_a=%0d", bus.estado, bus.op_a, a);
        end
        press_end();

        press_begin(b[3:0], c[0]);
        checks++;
        if (bus.estado !== 2'b10 || bus.op_b !== b[3:0] || bus.cin_out !== c[0] ||
            bus.op_a !== a[3:0] || bus.valido !== 1'b0) begin
            errors++;
            $display("FAIL load_b got estado=%0b op_a=%0d op_b=%0d cin=%0b valido=%0b required 10 %0d %0d %0d 0",
                     bus.estado, bus.op_a, bus.op_b, bus.cin_out, bus.valido, a, b, c);
        end
        tick();
        checks++;
        if (bus.estado !== 2'b11 || bus.valido !== 1'b1 || bus.resultado !== e_sum ||
            bus.carry !== e_carry || bus.zero !== e_zero || bus.overflow !== e_ovf ||
            bus.cin_out !== c[0]) begin
            errors++;
            $display("FAIL result got estado=%0b valido=%0b res=%0d carry=%0b zero=%0b ovf=%0b cin=%0b required 11 1 %0d %0b %0b %0b %0d",
                     bus.estado, bus.valido, bus.resultado, bus.carry, bus.zero, bus.overflow, bus.cin_out,
                     e_sum, e_carry, e_zero, e_ovf, c);
        end
        press_end();

        // Acknowledge press: back to ESPERA_A with result held
        press_begin(4'($urandom_range(0, 15)), 1'b0);
        checks++;
        if (bus.estado !== 2'b00 || bus.valido !== 1'b0 || bus.resultado !== e_sum ||
            bus.carry !== e_carry || bus.zero !== e_zero || bus.overflow !== e_ovf) begin
            errors++;
            $display("FAIL ack got estado=%0b valido=%0b res=%0d carry=%0b zero=%0b ovf=%0b required 00 0 %0d %0b %0b %0b",
                     bus.estado, bus.valido, bus.resultado, bus.carry, bus.zero, bus.overflow,
                     e_sum, e_carry, e_zero, e_ovf);
        end
        press_end();
        $display("op a=%0d b=%0d cin=%0d -> res=%0d carry=%0b zero=%0b ovf=%0b",
                 a, b, c, bus.resultado, bus.carry, bus.zero, bus.overflow);
    endtask

    task automatic test_basic();    run_op(5, 3, 0);  endtask
    task automatic test_wrap();     run_op(15, 1, 0); endtask
    task automatic test_carry_in(); run_op(7, 0, 1);  endtask

    task automatic test_hold();
        logic [3:0] v;
        v = 4'($urandom_range(1, 15));
        bus.dado  = v;
        bus.botao = 1'b1;
        repeat (50) tick();
        checks++;
        if (bus.estado !== 2'b01 || bus.op_a !== v) begin
            errors++;
            $display("FAIL hold_load got estado=%0b op_a=%0d required 01 %0d", bus.estado, bus.op_a, v);
        end
        bus.dado = ~v;
        repeat (5) tick();
        checks++;
        if (bus.estado !== 2'b01 || bus.op_a !== v) begin
            errors++;
            $display("FAIL hold_retain got estado=%0b op_a=%0d required 01 %0d", bus.estado, bus.op_a, v);
        end
        press_end();
        bus.limpar = 1'b1;
        tick();
        bus.limpar = 1'b0;
        checks++;
        if (bus.estado !== 2'b00 || bus.op_a !== 4'd0) begin
            errors++;
            $display("FAIL hold_clear got estado=%0b op_a=%0d required 00 0", bus.estado, bus.op_a);
        end
        $display("hold: op_a=%0d loaded once, cleared", v);
    endtask

    task automatic test_limpar();
        press_begin(4'd6, 1'b0);
        press_end();
        bus.dado   = 4'd9;
        bus.cin_in = 1'b1;
        bus.botao  = 1'b1;
        repeat (2) tick();
        bus.limpar = 1'b1;      // coincides with the B-load event
        tick();
        bus.limpar = 1'b0;
        checks++;
        if (bus.estado !== 2'b00 || bus.op_a !== 4'd0 || bus.op_b !== 4'd0 ||
            bus.cin_out !== 1'b0 || bus.valido !== 1'b0) begin
            errors++;
            $display("FAIL limpar got estado=%0b op_a=%0d op_b=%0d cin=%0b valido=%0b required 00 0 0 0 0",
                     bus.estado, bus.op_a, bus.op_b, bus.cin_out, bus.valido);
        end
        press_end();
        checks++;
        if (bus.estado !== 2'b00 || bus.op_a !== 4'd0) begin
            errors++;
            $display("FAIL limpar_no_reload got estado=%0b op_a=%0d required 00 0", bus.estado, bus.op_a);
        end
        $display("limpar: estado=%0b op_a=%0d op_b=%0d", bus.estado, bus.op_a, bus.op_b);
    endtask

    task automatic test_async_reset();
        logic [3:0] v;
        int seen_valid;
        seen_valid = 0;
        press_begin(4'd4, 1'b0);
        press_end();
        press_begin(4'd2, 1'b1);
        checks++;
        if (bus.estado !== 2'b10) begin
            errors++;
            $display("FAIL areset_pre got estado=%0b required 10", bus.estado);
        end
        #2;
        rst_n     = 1'b0;
        bus.botao = 1'b0;
        #1;
        checks++;
        if ({bus.op_a, bus.op_b, bus.cin_out, bus.resultado, bus.carry, bus.zero,
             bus.overflow, bus.valido, bus.estado} !== 18'd0) begin
            errors++;
            $display("FAIL areset_immediate got op_a=%0d op_b=%0d cin=%0b res=%0d valido=%0b estado=%0b required all zero",
                     bus.op_a, bus.op_b, bus.cin_out, bus.resultado, bus.valido, bus.estado);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.valido !== 1'b0) seen_valid++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.valido !== 1'b0) seen_valid++;
        end
        checks++;
        if (seen_valid != 0) begin
            errors++;
            $display("FAIL areset_valido got %0d cycles with valido=1 required 0", seen_valid);
        end
        v = 4'($urandom_range(1, 15));
        press_begin(v, 1'b0);
        checks++;
        if (bus.estado !== 2'b01 || bus.op_a !== v) begin
            errors++;
            $display("FAIL areset_reload got estado=%0b op_a=%0d required 01 %0d", bus.estado, bus.op_a, v);
        end
        press_end();
        bus.limpar = 1'b1;
        tick();
        bus.limpar = 1'b0;
        $display("async reset: reload op_a=%0d", v);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++)
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
    endtask

    initial begin
        bus.botao  = 1'b0;
        bus.limpar = 1'b0;
        bus.dado   = 4'd0;
        bus.cin_in = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_wrap();
        test_carry_in();
        test_hold();
        test_limpar();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/controle_operandos_ula.md
Name: controle_operandos_ula

Overview:
- Sequential front/back-end around the combinational 4-bit ripple adder. Uses a handshake-free pushbutton interface.
- Captures operand A, then operand B, from a WIDTH-bit switch bus on successive button presses, and drives both operands and carry-in onto the adder inputs.
- Registers the adder's sum and carry-out one cycle later and derives status flags for the display logic.
- Sits between the board I/O (switches/button) and the adder, and feeds the result/flag display.

Parameters:
- WIDTH, 4, operand/result width; must match the adder instance width.
- SYNC_STAGES, 2, flip-flop stages in the button synchronizer; minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- botao  input  1  raw asynchronous load/advance button, active-high
- limpar  input  1  synchronous clear, active-high, already synchronous to clk
- dado  input  WIDTH  switch operand bus
- cin_in  input  1  requested carry-in, sampled with operand B
- soma_in  input  WIDTH  sum from adder
- cout_in  input  1  carry-out from adder
- op_a  output  WIDTH  registered operand A to adder
- op_b  output  WIDTH  registered operand B to adder
- cin_out  output  1  registered carry-in to adder
- resultado  output  WIDTH  captured sum
- carry  output  1  captured carry-out
- zero  output  1  resultado == 0
- overflow  output  1  signed two's-complement overflow
- valido  output  1  result registers hold a fresh result
- estado  output  2  current FSM state encoding

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, synchronizer and edge-detect flops 0, estado = ESPERA_A (2'b00).
- Button synchronizer:
  - botao passes through SYNC_STAGES flops; a further flop holds the previous synchronized value.
  - ev is a one-cycle pulse when synchronized = 1 and previous = 0.
  - A held button yields exactly one ev. No debounce filter; bounce is handled externally.
- FSM states: ESPERA_A=00, ESPERA_B=01, CALCULA=10, RESULTADO=11.
  - ESPERA_A, ev: op_a <= dado; -> ESPERA_B.
  - ESPERA_B, ev: op_b <= dado, cin_out <= cin_in; -> CALCULA.
  - CALCULA (exactly 1 cycle, unconditional):
    - resultado <= soma_in, carry <= cout_in.
    - zero <= (soma_in == 0).
    - overflow <= (op_a[MSB] == op_b[MSB]) && (soma_in[MSB] != op_a[MSB]).
    - valido <= 1; -> RESULTADO.
  - RESULTADO, ev: valido <= 0; -> ESPERA_A. resultado/carry/zero/overflow hold their values until the next CALCULA.
  - With no ev, every state holds.
- Latency:
  - op_b/cin_out are valid at the adder inputs from the cycle after the B-load ev.
  - valido rises 2 cycles after the B-load ev (one cycle in CALCULA, registered on exit).
- Operand retention:
  - op_a is unchanged outside ESPERA_A loads; op_b and cin_out are unchanged outside ESPERA_B loads.
  - The adder therefore sees stable inputs throughout CALCULA.
- Simultaneous / boundary events:
  - ev during CALCULA is ignored and lost; no queueing.
  - limpar has priority over ev in the same cycle. It clears every register to its reset value, state -> ESPERA_A, and leaves synchronizer flops untouched.
  - rst_n asserted mid-operation, in any state: immediate return to reset values; no partial capture survives.
  - Arithmetic wraps modulo 2^WIDTH; carry is the unsigned overflow indicator, overflow the signed one. Both may be set simultaneously.
- estado output is the registered state, with no combinational path from inputs.

Test Plan:
- Reset, then press with dado=5, press with dado=3 and cin_in=0 -> op_a=5, op_b=3; 2 cycles after the second ev: resultado=8, carry=0, zero=0, overflow=1, valido=1, estado=11.
- Load 15 and 1, cin_in=0 -> resultado=0, carry=1, zero=1, overflow=0; next press -> valido=0, estado=00, resultado still 0.
- Load 7 and 0, cin_in=1 -> resultado=8, carry=0, overflow=1; cin_out=1 throughout CALCULA.
- Hold botao high for 50 cycles in ESPERA_A -> exactly one load, estado=01 and stays; changing dado afterwards does not alter op_a.
- Load A, then assert limpar in the same cycle as the B-press ev -> estado=00, op_a=op_b=0, valido=0; op_b is not loaded.
- Drop rst_n asynchronously (mid-cycle) while estado=10 -> all outputs 0 immediately, valido never asserts; after release, the next press loads A.
